// File: rtl/uart_calc_ctrl.sv
// uart_calc_ctrl: parses "<A><op><B>" from received bytes and computes the result.
// The result is converted to decimal ASCII and sent through the transmitter one byte
// at a time using a start/done handshake. Bad input or division by zero is answered
// with 'E' followed by the terminator.
module uart_calc_ctrl #(
  parameter int         MAX_DIGITS = 2,
  parameter logic [7:0] TERM_CHAR  = 8'h0D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  output logic [13:0] result,
  output logic        neg,
  output logic        result_valid,
  output logic        error,
  output logic        busy
);

  typedef enum logic [2:0] {
    GET_A, GET_B, CALC, DIV, CONV, SEND, WAIT_TX, ERR_SEND
  } state_e;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

  localparam logic [1:0] MAXC     = 2'(MAX_DIGITS);
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_E     = 8'h45;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [6:0]      a_q, a_d, b_q, b_d;
  logic [1:0]      cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [13:0]     work_q, work_d;    // DIV remainder, then CONV residue
  logic [13:0]     quot_q, quot_d;
  logic [13:0]     result_q, result_d;
  logic            neg_q, neg_d;
  logic [3:0][3:0] dig_q, dig_d;      // [0] = thousands ... [3] = units
  logic [1:0]      pos_q, pos_d;
  logic [2:0]      sidx_q, sidx_d;    // next reply slot: 0 sign, 1..4 digits, 5 terminator
  logic            last_q, last_d;    // the outstanding byte ends the reply
  logic            err_q, err_d;      // reply in progress is the error reply
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            result_valid_q, result_valid_d;
  logic            error_q, error_d;

  // weight of each decimal position, most significant first
  function automatic logic [13:0] weight(input logic [1:0] p);
    case (p)
      2'd0:    weight = 14'd1000;
      2'd1:    weight = 14'd100;
      2'd2:    weight = 14'd10;
      default: weight = 14'd1;
    endcase
  endfunction

  // received byte classification
  logic is_digit, is_op;
  op_e  rx_op;
  always_comb begin
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_op    = 1'b1;
    rx_op    = OP_ADD;
    case (rx_data)
      8'h2B:   rx_op = OP_ADD;
      8'h2D:   rx_op = OP_SUB;
      8'h2A:   rx_op = OP_MUL;
      8'h2F:   rx_op = OP_DIV;
      default: is_op = 1'b0;
    endcase
  end

  // pick the next reply slot to send: sign only if negative, leading zeros dropped,
  // units digit and terminator always present
  logic [5:0] send_mask;
  logic [2:0] send_sel;
  logic [7:0] send_byte;
  logic       nz;
  always_comb begin
    send_mask    = '0;
    send_mask[0] = neg_q;
    nz           = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nz             = nz | (dig_q[k] != 4'd0);
      send_mask[k+1] = nz | (k == 3);
    end
    send_mask[5] = 1'b1;
    send_sel     = 3'd5;
    for (int k = 5; k >= 0; k--)
      if (send_mask[k] && (3'(k) >= sidx_q)) send_sel = 3'(k);
    if (send_sel == 3'd0)      send_byte = CH_MINUS;
    else if (send_sel == 3'd5) send_byte = TERM_CHAR;
    else                       send_byte = {4'h3, dig_q[2'(send_sel - 3'd1)]};
  end

  // next-state and datapath
  logic        go_err, go_conv, clr;
  logic [13:0] conv_val;
  logic        conv_neg;
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    cnt_a_d        = cnt_a_q;
    cnt_b_d        = cnt_b_q;
    work_d         = work_q;
    quot_d         = quot_q;
    result_d       = result_q;
    neg_d          = neg_q;
    dig_d          = dig_q;
    pos_d          = pos_q;
    sidx_d         = sidx_q;
    last_d         = last_q;
    err_d          = err_q;
    tx_data_d      = tx_data_q;
    tx_start_d     = 1'b0;
    result_valid_d = 1'b0;
    error_d        = 1'b0;
    go_err         = 1'b0;
    go_conv        = 1'b0;
    clr            = 1'b0;
    conv_val       = '0;
    conv_neg       = 1'b0;

    case (state_q)
      GET_A: if (rx_done) begin
        if (is_digit) begin
          if (cnt_a_q == MAXC) go_err = 1'b1;
          else begin
            a_d     = a_q * 7'd10 + {3'd0, rx_data[3:0]};
            cnt_a_d = cnt_a_q + 2'd1;
          end
        end else if (is_op) begin
          if (cnt_a_q != 2'd0) begin
            op_d    = rx_op;
            state_d = GET_B;
          end else go_err = 1'b1;
        end else if (rx_data != CH_SPACE) go_err = 1'b1;
      end

      GET_B: if (rx_done) begin
        if (is_digit) begin
          if (cnt_b_q == MAXC) go_err = 1'b1;
          else begin
            b_d     = b_q * 7'd10 + {3'd0, rx_data[3:0]};
            cnt_b_d = cnt_b_q + 2'd1;
            // a full-width B needs no terminator
            if (cnt_b_q + 2'd1 == MAXC) state_d = CALC;
          end
        end else if (rx_data == TERM_CHAR) begin
          if (cnt_b_q != 2'd0) state_d = CALC;
          else go_err = 1'b1;
        end else if (rx_data != CH_SPACE) go_err = 1'b1;
      end

      CALC: begin
        case (op_q)
          OP_ADD: begin go_conv = 1'b1; conv_val = 14'(a_q) + 14'(b_q); end
          OP_MUL: begin go_conv = 1'b1; conv_val = 14'(a_q) * 14'(b_q); end
          OP_SUB: begin
            go_conv  = 1'b1;
            conv_neg = (a_q < b_q);
            conv_val = (a_q < b_q) ? 14'(b_q - a_q) : 14'(a_q - b_q);
          end
          default: begin
            if (b_q == 7'd0) go_err = 1'b1;
            else begin
              work_d  = 14'(a_q);
              quot_d  = '0;
              state_d = DIV;
            end
          end
        endcase
      end

      // one subtraction per cycle; the cycle that fails to subtract hands off
      DIV: begin
        if (work_q >= 14'(b_q)) begin
          work_d = work_q - 14'(b_q);
          quot_d = quot_q + 14'd1;
        end else begin
          go_conv  = 1'b1;
          conv_val = quot_q;
        end
      end

      // digit d at a position costs d subtract cycles plus one advance cycle
      CONV: begin
        if (work_q >= weight(pos_q)) begin
          work_d       = work_q - weight(pos_q);
          dig_d[pos_q] = dig_q[pos_q] + 4'd1;
        end else if (pos_q == 2'd3) begin
          sidx_d  = '0;
          err_d   = 1'b0;
          state_d = SEND;
        end else pos_d = pos_q + 2'd1;
      end

      SEND: begin
        tx_data_d  = send_byte;
        tx_start_d = 1'b1;
        sidx_d     = send_sel + 3'd1;
        last_d     = (send_sel == 3'd5);
        state_d    = WAIT_TX;
      end

      ERR_SEND: begin
        tx_data_d  = (sidx_q == 3'd0) ? CH_E : TERM_CHAR;
        tx_start_d = 1'b1;
        last_d     = (sidx_q != 3'd0);
        sidx_d     = sidx_q + 3'd1;
        state_d    = WAIT_TX;
      end

      // a done in the same cycle as our start pulse cannot belong to this byte
      WAIT_TX: if (tx_done && !tx_start_q) begin
        if (last_q) begin
          clr     = 1'b1;
          state_d = GET_A;
        end else state_d = err_q ? ERR_SEND : SEND;
      end

      default: state_d = GET_A;
    endcase

    if (go_conv) begin
      result_d       = conv_val;
      neg_d          = conv_neg;
      work_d         = conv_val;
      result_valid_d = 1'b1;
      dig_d          = '0;
      pos_d          = '0;
      state_d        = CONV;
    end

    if (go_err) begin
      error_d = 1'b1;
      err_d   = 1'b1;
      sidx_d  = '0;
      state_d = ERR_SEND;
    end

    if (clr) begin
      a_d     = '0;
      b_d     = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      op_d    = OP_ADD;
      last_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= GET_A;
      op_q           <= OP_ADD;
      a_q            <= '0;
      b_q            <= '0;
      cnt_a_q        <= '0;
      cnt_b_q        <= '0;
      work_q         <= '0;
      quot_q         <= '0;
      result_q       <= '0;
      neg_q          <= 1'b0;
      dig_q          <= '0;
      pos_q          <= '0;
      sidx_q         <= '0;
      last_q         <= 1'b0;
      err_q          <= 1'b0;
      tx_data_q      <= '0;
      tx_start_q     <= 1'b0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      a_q            <= a_d;
      b_q            <= b_d;
      cnt_a_q        <= cnt_a_d;
      cnt_b_q        <= cnt_b_d;
      work_q         <= work_d;
      quot_q         <= quot_d;
      result_q       <= result_d;
      neg_q          <= neg_d;
      dig_q          <= dig_d;
      pos_q          <= pos_d;
      sidx_q         <= sidx_d;
      last_q         <= last_d;
      err_q          <= err_d;
      tx_data_q      <= tx_data_d;
      tx_start_q     <= tx_start_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign result       = result_q;
  assign neg          = neg_q;
  assign result_valid = result_valid_q;
  assign error        = error_q;
  assign busy         = !((state_q == GET_A) || (state_q == GET_B));

endmodule

// File: tb/tb_uart_calc_ctrl.sv
// Directed bench for uart_calc_ctrl: byte-level receiver stimulus and a
// transmitter responder that records every byte handed over.
module tb_uart_calc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic [13:0] result;
  logic        neg, result_valid, error, busy;

  uart_calc_ctrl #(.MAX_DIGITS(2), .TERM_CHAR(8'h0D)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .result(result), .neg(neg), .result_valid(result_valid),
    .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] txq[$];
  int         tx_starts = 0;
  int         tx_bad = 0;
  int         tx_delay = 20;
  logic       hold_tx = 1'b0;

  int          rv_cnt = 0;
  int          err_cnt = 0;
  logic [13:0] rv_res = '0;

  // pulse monitors
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin rv_cnt++; rv_res = result; end
    if (error === 1'b1) err_cnt++;
  end

  // transmitter model: take the byte on tx_start, check it stays put, answer tx_done
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx_start === 1'b1) begin
        logic [7:0] b;
        int         n;
        logic       aborted;
        b = tx_data;
        txq.push_back(b);
        tx_starts++;
        n = 0;
        aborted = 1'b0;
        while (!aborted && (hold_tx || n < tx_delay)) begin
          @(negedge clk);
          n++;
          if (!rst_n) aborted = 1'b1;
          else if (tx_data !== b || tx_start !== 1'b0) tx_bad++;
        end
        if (!aborted) begin
          tx_done = 1'b1;
          @(negedge clk);
          tx_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (30) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] txpack();
    logic [63:0] v;
    v = '0;
    foreach (txq[i]) v = {v[55:0], txq[i]};
    return v;
  endfunction

  initial begin
    int s0, rv0, e0, n;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_neg", 64'(neg), 64'd0);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full-width B starts the calculation without a terminator
    txq.delete(); rv0 = rv_cnt;
    send_str("87*93");
    wait_idle("mul_idle");
    chk("mul_result", 64'(result), 64'd8091);
    chk("mul_neg", 64'(neg), 64'd0);
    chk("mul_tx", txpack(), 64'h38_30_39_31_0D);
    chk("mul_rv_count", 64'(rv_cnt - rv0), 64'd1);
    chk("mul_rv_result", 64'(rv_res), 64'd8091);

    // negative difference; the trailing terminator lands while busy
    txq.delete();
    send_str("5-12"); send_byte(8'h0D);
    wait_idle("sub_idle");
    chk("sub_result", 64'(result), 64'd7);
    chk("sub_neg", 64'(neg), 64'd1);
    chk("sub_tx", txpack(), 64'h2D_37_0D);

    // division by zero: error reply, result untouched
    txq.delete(); e0 = err_cnt; rv0 = rv_cnt;
    send_str("99/0"); send_byte(8'h0D);
    wait_idle("div0_idle");
    chk("div0_err", 64'(err_cnt - e0), 64'd1);
    chk("div0_tx", txpack(), 64'h45_0D);
    chk("div0_no_rv", 64'(rv_cnt - rv0), 64'd0);
    chk("div0_result_hold", 64'(result), 64'd7);

    txq.delete();
    send_str("7/2"); send_byte(8'h0D);
    wait_idle("div_idle");
    chk("div_result", 64'(result), 64'd3);
    chk("div_neg", 64'(neg), 64'd0);
    chk("div_tx", txpack(), 64'h33_0D);

    txq.delete();
    send_str("99/7"); send_byte(8'h0D);
    wait_idle("div14_idle");
    chk("div14_result", 64'(result), 64'd14);
    chk("div14_tx", txpack(), 64'h31_34_0D);

    // too many digits in A
    txq.delete(); e0 = err_cnt;
    send_str("123");
    wait_idle("long_idle");
    chk("long_err", 64'(err_cnt - e0), 64'd1);
    chk("long_tx", txpack(), 64'h45_0D);

    txq.delete();
    send_str("4+4"); send_byte(8'h0D);
    wait_idle("add_idle");
    chk("add_result", 64'(result), 64'd8);
    chk("add_tx", txpack(), 64'h38_0D);

    // spaces are ignored, even between digits
    txq.delete();
    send_str("1 2-3 4");
    wait_idle("space_idle");
    chk("space_result", 64'(result), 64'd22);
    chk("space_neg", 64'(neg), 64'd1);
    chk("space_tx", txpack(), 64'h2D_32_32_0D);

    // operator with no A digits
    txq.delete(); e0 = err_cnt;
    send_str("*");
    wait_idle("op_first_idle");
    chk("op_first_err", 64'(err_cnt - e0), 64'd1);
    chk("op_first_tx", txpack(), 64'h45_0D);

    // zero result; transmitter stalls for 1000 cycles
    txq.delete(); hold_tx = 1'b1; s0 = tx_starts;
    send_str("0*5"); send_byte(8'h0D);
    repeat (1000) @(negedge clk);
    chk("hold_starts", 64'(tx_starts - s0), 64'd1);
    chk("hold_tx_data", 64'(tx_data), 64'h30);
    chk("hold_busy", 64'(busy), 64'd1);
    hold_tx = 1'b0;
    wait_idle("zero_idle");
    chk("zero_result", 64'(result), 64'd0);
    chk("zero_tx", txpack(), 64'h30_0D);
    chk("tx_stable", 64'(tx_bad), 64'd0);

    // reset while the reply is being sent
    txq.delete(); tx_delay = 40;
    send_str("87*93");
    n = 0;
    while (txq.size() < 2 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_second_byte", 64'(txq.size() >= 2), 64'd1);
    chk("mid_first_byte", 64'(txq[0]), 64'h38);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_tx_data", 64'(tx_data), 64'd0);
    chk("mid_rst_tx_start", 64'(tx_start), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    chk("mid_rst_neg", 64'(neg), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_error", 64'(error), 64'd0);
    rst_n = 1'b1;
    tx_delay = 20;
    s0 = tx_starts;
    repeat (300) @(negedge clk);
    chk("mid_no_start", 64'(tx_starts - s0), 64'd0);

    txq.delete();
    send_str("2+3"); send_byte(8'h0D);
    wait_idle("post_rst_idle");
    chk("post_rst_result", 64'(result), 64'd5);
    chk("post_rst_tx", txpack(), 64'h35_0D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_calc_ctrl.md
# uart_calc_ctrl

Sequencing controller between the UART receiver and UART transmitter of the serial calculator top level. Parses an ASCII expression of the form `<A><op><B>` from received bytes and computes the result with an internal multi-cycle datapath. Converts the result to decimal ASCII and drives the transmitter byte by byte through a start/done handshake. Malformed input or division by zero answers `E` followed by the terminator.

## Interface
Parameters:
- MAX_DIGITS, 2, maximum decimal digits per operand; legal values are 1..2, so results fit in 14 bits and 4 decimal digits.
- TERM_CHAR, 8'h0D, byte that terminates operand B and ends every reply.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from the UART receiver; valid while rx_done is high.
- rx_done  in  1  one-cycle pulse: a byte has been received.
- tx_data  out  8  byte to send; held stable from tx_start until tx_done.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_done  in  1  one-cycle pulse from the transmitter after the stop bit.
- result  out  14  magnitude of the last computed result.
- neg  out  1  sign of the last result (1 = negative).
- result_valid  out  1  one-cycle pulse when result and neg are updated.
- error  out  1  one-cycle pulse on entry to the error path.
- busy  out  1  high in every state except GET_A and GET_B.

## Operation
- States: GET_A, GET_B, CALC, DIV, CONV, SEND, WAIT_TX, ERR_SEND.
- GET_A:
  - A digit byte (8'h30..8'h39) sets A = A*10 + d and increments cntA.
  - A digit that arrives when cntA == MAX_DIGITS goes to the error path.
  - An operator (`+ - * /`) with cntA ≥ 1 latches op and moves to GET_B.
  - An operator with cntA == 0 goes to the error path.
- GET_B:
  - A digit byte accumulates into B the same way.
  - When cntB reaches MAX_DIGITS, the controller moves to CALC on the next cycle without waiting for a terminator.
  - TERM_CHAR with cntB ≥ 1 moves to CALC.
  - An operator, or TERM_CHAR with cntB == 0, goes to the error path.
- Space (8'h20) is ignored in GET_A and GET_B. Any other byte goes to the error path.
- Bytes whose rx_done falls in any other state are discarded.
- CALC takes one cycle:
  - `+` gives A+B.
  - `*` gives A*B.
  - `-` gives |A−B| with neg = (A<B).
  - `/` with B == 0 goes to the error path.
  - `/` with B ≠ 0 goes to DIV.
- DIV: restoring repeated subtraction, one subtraction of B per cycle. The quotient is truncated, the remainder is discarded, and neg = 0.
- CONV:
  - Digit positions are 1000, 100, 10 and 1, in that order.
  - For each position, subtract repeatedly, one subtraction per cycle, then spend one cycle advancing to the next position.
  - Digit d therefore takes d+1 cycles, and CONV lasts sum(d)+4 cycles.
  - result_valid pulses in the first CONV cycle.
- SEND order:
  - `-` if neg is set.
  - Then the digits with leading zeros suppressed; the units digit is always sent.
  - Then TERM_CHAR.
- Each byte is sent with one tx_start pulse followed by WAIT_TX until tx_done.
- After the terminator's tx_done:
  - A, B, cntA, cntB and op are cleared and the controller returns to GET_A.
  - result and neg hold their values.
- Error path: pulse error, send 8'h45 (`E`), then TERM_CHAR, then clear the parser and return to GET_A.

## Timing
- Reset values:
  - State GET_A, with A, B, counts and op at 0.
  - tx_data = 0, tx_start = 0, result = 0, neg = 0, result_valid = 0, error = 0, busy = 0.
- Reset is honoured mid-operation, including mid-send. No further tx_start is issued after release until a new expression completes.
- Latency, non-divide: rx_done of the last byte at cycle t gives CALC at t+1 and CONV at t+2. The first tx_start comes 1 cycle after CONV ends.
- Divide adds q+1 cycles for quotient q (at most 100).
- tx_start is never issued while a previous byte awaits tx_done.
- A tx_done that arrives when no byte is outstanding is ignored.
- rx_done and tx_done arriving in the same cycle: tx_done is processed and rx_done is discarded, because the controller is busy.

## Test plan
- Send "87*93" at 624 clk/bit → result_valid with result = 8091 and neg = 0; tx bytes are 38 30 39 31 0D; no terminator is needed.
- Send "5-12",0D → neg = 1, result = 7; tx bytes are 2D 37 0D.
- Send "99/0",0D → error pulse; tx bytes are 45 0D; busy returns to 0. Then "7/2",0D → result = 3; tx bytes are 33 0D.
- Send "123" → error on the third digit; tx bytes are 45 0D. Then "4+4",0D → tx bytes are 38 0D.
- Send "0*5",0D → result = 0; tx bytes are 30 0D. Hold tx_done off for 1000 cycles → tx_start pulses exactly once and tx_data stays stable.
- Assert rst_n low after the first digit of "8091" has been sent → all outputs return to reset values. Then "2+3",0D → tx bytes are 35 0D.
